// File: rtl/fft_pkg.sv
// Shared FFT pipeline types, default sizes and the bit-reversal helper.
package fft_pkg;

    localparam int unsigned FftN    = 3;
    localparam int unsigned FftW    = 16;
    localparam int unsigned FftMaxN = 16;

    typedef struct packed {
        logic signed [FftW-1:0] re;
        logic signed [FftW-1:0] im;
    } cplx_t;

    typedef enum logic [0:0] {
        StIdle,
        StStream
    } rd_state_e;

    // Reverses the low n bits of value; upper bits of the result are zero.
    function automatic logic [FftMaxN-1:0] bitrev(input logic [FftMaxN-1:0] value, input int n);
        logic [FftMaxN-1:0] v;
        logic [FftMaxN-1:0] r;
        v = value;
        r = '0;
        for (int i = 0; i < int'(FftMaxN); i++) begin
            if (i < n) begin
                r = {r[FftMaxN-2:0], v[0]};
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One frame store of 2^N complex entries: one write port, one registered read port.
module fft_reorder_bank #(
    parameter int unsigned N = fft_pkg::FftN,
    parameter type entry_t = fft_pkg::cplx_t
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [N-1:0] waddr,
    input  entry_t       wdata,
    input  logic         re,
    input  logic [N-1:0] raddr,
    output entry_t       rdata
);

    entry_t mem [2**N];
    entry_t rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register is reset so the top's outputs come up as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT stream in, natural-order frames out.
// Optional FFT_REORDER_SCALE_EN: outputs arithmetically shifted right by N.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int unsigned N = FftN,
    parameter int unsigned W = FftW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic signed [W-1:0] in_re,
    input  logic signed [W-1:0] in_im,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_re,
    output logic signed [W-1:0] out_im,
    output logic [N-1:0]        out_idx,
    output logic                out_last,
    output logic                overflow
);

    typedef struct packed {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
    } sample_t;

    localparam logic [N-1:0] CntMax = '1;

    logic [1:0]   full_q, full_d;
    logic         wr_bank_q, wr_bank_d;
    logic         rd_bank_q, rd_bank_d;
    logic [N-1:0] wr_cnt_q, wr_cnt_d;
    logic [N-1:0] rd_cnt_q, rd_cnt_d;
    rd_state_e    state_q, state_d;
    logic         overflow_q, overflow_d;

    logic               release_bank;
    logic               wr_blocked;
    logic               wr_en;
    logic               rd_load;
    logic               rd_load_bank;
    logic [N-1:0]       rd_addr;
    logic [FftMaxN-1:0] wr_rev;
    logic               unused_rev_hi;
    sample_t            wr_data;
    sample_t            rd_data [2];
    sample_t            out_data;

    assign release_bank = (state_q == StStream) && out_ready && (rd_cnt_q == CntMax);
    // A bank released by the reader this cycle is writable in the same cycle.
    assign wr_blocked   = full_q[wr_bank_q] && !(release_bank && (rd_bank_q == wr_bank_q));
    assign wr_en        = in_valid && !wr_blocked;
    assign wr_rev       = bitrev(FftMaxN'(wr_cnt_q), int'(N));
    assign unused_rev_hi = ^wr_rev[FftMaxN-1:N];
    assign wr_data      = '{re: in_re, im: in_im};

    always_comb begin
        full_d       = full_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        state_d      = state_q;
        overflow_d   = overflow_q;
        rd_load      = 1'b0;
        rd_load_bank = rd_bank_q;
        rd_addr      = rd_cnt_q;

        if (in_valid && wr_blocked) begin
            overflow_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (full_q[rd_bank_q]) begin
                    rd_load = 1'b1;
                    state_d = StStream;
                end
            end
            StStream: begin
                if (out_ready) begin
                    if (rd_cnt_q == CntMax) begin
                        full_d[rd_bank_q] = 1'b0;
                        rd_bank_d         = !rd_bank_q;
                        rd_cnt_d          = '0;
                        if (full_q[!rd_bank_q]) begin
                            rd_load      = 1'b1;
                            rd_load_bank = !rd_bank_q;
                            rd_addr      = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                        rd_load  = 1'b1;
                        rd_addr  = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (wr_en) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == CntMax) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            state_q    <= StIdle;
            overflow_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_reorder_bank #(
            .N       (N),
            .entry_t (sample_t)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (wr_en && (wr_bank_q == 1'(b))),
            .waddr (wr_rev[N-1:0]),
            .wdata (wr_data),
            .re    (rd_load && (rd_load_bank == 1'(b))),
            .raddr (rd_addr),
            .rdata (rd_data[b])
        );
    end

    // The bank being drained always owns the presented read register.
    assign out_data = rd_data[rd_bank_q];

`ifdef FFT_REORDER_SCALE_EN
    assign out_re = $signed(out_data.re) >>> N;
    assign out_im = $signed(out_data.im) >>> N;
`else
    assign out_re = out_data.re;
    assign out_im = out_data.im;
`endif

    assign out_valid = (state_q == StStream);
    assign out_idx   = rd_cnt_q;
    assign out_last  = out_valid && (rd_cnt_q == CntMax);
    assign overflow  = overflow_q;

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Output reorder buffer at the tail of the radix-2 SDF FFT pipeline. Consumes the serial complex stream from the last butterfly stage, which arrives in bit-reversed frequency order, one sample per cycle with no backpressure. Emits each 2^N-point frame in natural frequency order over a valid/ready handshake. Ping-pong banks let the FFT write frame f+1 while frame f drains.

## Interface
- N, default 3: log2 of FFT points; frame length 2^N.
- W, default 16: signed fixed-point width of each real/imag component.
- clk  in  1: clock; all state updates on posedge.
- rst_n  in  1: reset, asynchronous, active-low.
- in_valid  in  1: input sample present this cycle; cannot be stalled.
- in_re, in_im  in  W each: signed input sample.
- out_valid  out  1: output sample valid.
- out_ready  in  1: sink accepts the sample when out_valid && out_ready.
- out_re, out_im  out  W each: signed output sample.
- out_idx  out  N: natural frequency index of the current output.
- out_last  out  1: high with out_idx == 2^N-1.
- overflow  out  1: sticky; set when an input sample was dropped.

## Operation
- Two banks of 2^N complex entries each. Per bank: full flag. Pointers: wr_bank, rd_bank (1 bit each), wr_cnt and rd_cnt (N bits each).
- Write: in_valid with bank wr_bank not full stores the sample at address bitrev(wr_cnt), then increments wr_cnt. When wr_cnt wraps from 2^N-1 to 0, the bank's full flag is set and wr_bank toggles.
- Drop: in_valid while bank wr_bank is full discards the sample. wr_cnt does not advance, and overflow is set.
- Release bypass: if the reader releases a bank in the same cycle, that bank counts as not full for the write in that cycle.
- Read FSM:
  - IDLE: go to STREAM when bank rd_bank becomes full.
  - STREAM: present address rd_cnt; on each handshake, increment rd_cnt.
  - On the handshake with rd_cnt == 2^N-1: clear the bank's full flag and toggle rd_bank. If the other bank is already full, stay in STREAM; otherwise return to IDLE.
- out_idx = rd_cnt. Output data is registered and held stable while out_valid && !out_ready.
- Arithmetic: pure data movement, no width change, except when scaling is compiled in (see Configuration).

## Timing
- Reset values: out_valid 0, out_re/out_im 0, out_idx 0, out_last 0, overflow 0. All counters, pointers and full flags are 0; FSM is IDLE.
- Reset asserted mid-frame discards both banks immediately. After release, the first in_valid is treated as index 0 of a new frame.
- Latency: the last input of a frame is written at edge t. out_valid rises after edge t+1, presenting out_idx 0.
- Throughput: 1 sample/cycle in both directions with out_ready held high. Back-to-back frames then never overflow.
- Gap-free output: output is continuous across frames when the next bank is full at the last handshake.
- Input gaps: in_valid low simply pauses wr_cnt. No timeout.

## Configuration
- FFT_REORDER_SCALE_EN:
  - Defined: out_re/out_im = stored value arithmetically shifted right by N (floor), i.e. 1/2^N normalisation for IFFT use. The shift is applied in the output register stage and adds no latency.
  - Undefined: samples pass unmodified.

## Structure
- fft_pkg holds:
  - cplx_t packed struct {re, im} of W bits.
  - bitrev(value, N) function.
  - Default N and W constants, shared with the butterfly stages.
- One sub-module: fft_reorder_bank. Single 2^N-entry cplx_t array with one write port and one registered read port; instantiated twice.
- Control (counters, full flags, FSM, overflow) stays in the top.

## Test plan
- Single frame, N=3, W=16: inputs re=k, im=-k for k=0..7, out_ready=1. Required: out_re sequence 0,4,2,6,1,5,3,7 with matching im values; out_idx 0..7; out_last on the 8th output; out_valid rises 2 cycles after the last input.
- Backpressure: toggle out_ready 1,0,0,1 repeatedly. Required: same order, no duplicates or losses, data stable while stalled.
- Back-to-back frames: 3 frames of 8 continuous samples, out_ready=1. Required: 24 consecutive outputs with no out_valid gap, overflow stays 0.
- Overflow: out_ready=0 while 17 samples are sent. Required: first 16 stored, 17th dropped, overflow=1 and stays set.
- Reset mid-frame: 5 samples, assert rst_n low for 1 cycle, then 8 samples. Required: all outputs at reset values during reset; one frame out, built only from the post-reset samples.
- With FFT_REORDER_SCALE_EN, N=3: inputs re=-9, 16, 7, ... Required: -9 emits -2; 16 emits 2; 7 emits 0.
